// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding, access-size codes and alignment helper for the load/store unit
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      READ   = 3'd1,
      RMW_RD = 3'd2,
      RMW_WR = 3'd3,
      WRITE  = 3'd4,
      RESP   = 3'd5
   } lsuState_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
      return ((size == SZ_HALF) && addrLo[0]) || ((size == SZ_WORD) && (addrLo != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - little-endian lane extraction/extension for loads and lane merge for sub-word stores
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addrLo,
   input  logic [1:0]  size,
   input  logic        isSigned,
   input  logic [31:0] wdata,
   output logic [31:0] loadData,
   output logic [31:0] mergedWord
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   always_comb begin
      byteSel = word[{addrLo, 3'b000} +: 8];
      halfSel = addrLo[1] ? word[31:16] : word[15:0];

      loadData = word;
      case (size)
         SZ_BYTE: loadData = {{24{isSigned & byteSel[7]}}, byteSel};
         SZ_HALF: loadData = {{16{isSigned & halfSel[15]}}, halfSel};
         default: loadData = word;
      endcase

      mergedWord = word;
      case (size)
         SZ_BYTE: mergedWord[{addrLo, 3'b000} +: 8] = wdata[7:0];
         SZ_HALF: begin
            if (addrLo[1]) mergedWord[31:16] = wdata[15:0];
            else           mergedWord[15:0]  = wdata[15:0];
         end
         default: mergedWord = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - d_mem initiator: FSM, request latch, memory-side and response registers
// Optional LSU_BOUNDS_CHECK_EN turns word indices >= DEPTH_WORDS into error responses.
module load_store_unit #(
   parameter logic [31:0] DATA_BASE   = 32'h1001_0000,
   parameter int          DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] Address,
   output logic [31:0] WriteData,
   input  logic [31:0] ReadData
);
   import lsu_pkg::*;

`ifdef LSU_BOUNDS_CHECK_EN
   localparam bit BoundsEn = 1'b1;
`else
   localparam bit BoundsEn = 1'b0;
`endif

   lsuState_t   state, stateNext;
   logic [1:0]  sizeQ, addrLoQ;
   logic        signedQ;
   logic [31:0] wdataQ;
   logic [31:0] wordIdx;
   logic        outOfRange, reqErr, accept;
   logic [31:0] loadData, mergedWord;

   // Subtraction wraps modulo 2^32; the word index is bits [31:2] of the difference.
   assign wordIdx    = (req_addr - DATA_BASE) >> 2;
   assign outOfRange = wordIdx >= 32'(DEPTH_WORDS);
   assign reqErr     = (req_size == SZ_RSVD) || isMisaligned(req_size, req_addr[1:0])
                       || (BoundsEn && outOfRange);
   assign accept     = req_valid && req_ready;

   lsu_align uAlign (
      .word       (ReadData),
      .addrLo     (addrLoQ),
      .size       (sizeQ),
      .isSigned   (signedQ),
      .wdata      (wdataQ),
      .loadData   (loadData),
      .mergedWord (mergedWord)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (reqErr)                 stateNext = RESP;
               else if (!req_write)        stateNext = READ;
               else if (req_size == SZ_WORD) stateNext = WRITE;
               else                        stateNext = RMW_RD;
            end
         end
         READ:    stateNext = RESP;
         RMW_RD:  stateNext = RMW_WR;
         RMW_WR:  stateNext = RESP;
         WRITE:   stateNext = RESP;
         RESP:    if (rsp_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Memory strobes decode only the state register so d_mem never sees req_* glitches.
   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == RESP);
      MemRead   = (state == READ) || (state == RMW_RD);
      MemWrite  = (state == RMW_WR) || (state == WRITE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sizeQ     <= SZ_BYTE;
         addrLoQ   <= 2'b00;
         signedQ   <= 1'b0;
         wdataQ    <= 32'h0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
         Address   <= 32'h0;
         WriteData <= 32'h0;
      end else begin
         if (accept) begin
            sizeQ     <= req_size;
            addrLoQ   <= req_addr[1:0];
            signedQ   <= req_signed;
            wdataQ    <= req_wdata;
            rsp_err   <= reqErr;
            rsp_rdata <= 32'h0;
            if (!reqErr) begin
               Address   <= wordIdx;
               WriteData <= req_wdata;
            end
         end
         if (state == READ)   rsp_rdata <= loadData;
         if (state == RMW_RD) WriteData <= mergedWord;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed-vector bench for load_store_unit with a behavioural d_mem
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        req_ready, rsp_valid, rsp_err, MemRead, MemWrite;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata, Address, WriteData, ReadData;

   logic [31:0] ram [256];
   logic        pokeEn = 1'b0;
   logic [7:0]  pokeIdx = 8'h0;
   logic [31:0] pokeVal = 32'h0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData),
      .ReadData(ReadData)
   );

   assign ReadData = (Address < 32'd256) ? ram[Address[7:0]] : 32'h0;

   always @(posedge clk) begin
      if (MemWrite) ram[Address[7:0]] <= WriteData;
      if (pokeEn)   ram[pokeIdx] <= pokeVal;
   end

   task automatic poke(input logic [7:0] idx, input logic [31:0] val);
      @(negedge clk);
      pokeEn = 1'b1; pokeIdx = idx; pokeVal = val;
      @(posedge clk);
      #1 pokeEn = 1'b0;
   endtask

   task automatic doReq(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nRd, output int nWr);
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; nRd = 0; nWr = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (MemRead)  nRd++;
         if (MemWrite) nWr++;
         if (rsp_valid) break;
      end
      checks++;
      if (rsp_valid !== 1'b1) begin
         failures++;
         $display("FAIL rsp_timeout addr=%h got rsp_valid=%b exp=1", a, rsp_valid);
      end
      rd = rsp_rdata;
      er = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({req_ready, rsp_valid, rsp_err, MemRead, MemWrite} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=10000", {req_ready, rsp_valid, rsp_err, MemRead, MemWrite});
      end
      checks++;
      if ({rsp_rdata, Address, WriteData} !== 96'h0) begin
         failures++;
         $display("FAIL reset_data got rdata=%h addr=%h wdata=%h exp=0", rsp_rdata, Address, WriteData);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_load();
      logic [31:0] addrs [6] = '{32'h1001_0001, 32'h1001_0001, 32'h1001_0002,
                                 32'h1001_0002, 32'h1001_0000, 32'h1001_0003};
      logic [1:0]  sizes [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
      logic        sgns  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] exps  [6] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899,
                                 32'h0000_8899, 32'h8899_AABB, 32'hFFFF_FF88};
      int lat, nRd, nWr;
      logic [31:0] rd;
      logic er;
      poke(8'd0, 32'h8899_AABB);
      for (int i = 0; i < 6; i++) begin
         doReq(1'b0, sizes[i], sgns[i], addrs[i], 32'h0, lat, rd, er, nRd, nWr);
         checks++;
         if (rd !== exps[i] || er !== 1'b0) begin
            failures++;
            $display("FAIL load_%0d got rdata=%h err=%b exp rdata=%h err=0", i, rd, er, exps[i]);
         end
         checks++;
         if (lat != 2 || nRd != 1 || nWr != 0) begin
            failures++;
            $display("FAIL load_timing_%0d got lat=%0d rd=%0d wr=%0d exp lat=2 rd=1 wr=0", i, lat, nRd, nWr);
         end
      end
   endtask

   task automatic test_store_subword();
      int lat, nRd, nWr;
      logic [31:0] rd;
      logic er;
      doReq(1'b1, 2'b00, 1'b0, 32'h1001_0002, 32'h0000_0055, lat, rd, er, nRd, nWr);
      checks++;
      if (ram[0] !== 32'h8855_AABB) begin
         failures++;
         $display("FAIL sb_ram got=%h exp=8855aabb", ram[0]);
      end
      checks++;
      if (lat != 3 || nRd != 1 || nWr != 1 || rd !== 32'h0 || er !== 1'b0) begin
         failures++;
         $display("FAIL sb_timing got lat=%0d rd=%0d wr=%0d rdata=%h err=%b exp 3 1 1 0 0", lat, nRd, nWr, rd, er);
      end
      doReq(1'b1, 2'b01, 1'b0, 32'h1001_0000, 32'hFFFF_1234, lat, rd, er, nRd, nWr);
      checks++;
      if (ram[0] !== 32'h8855_1234 || lat != 3) begin
         failures++;
         $display("FAIL sh_ram got=%h lat=%0d exp=88551234 lat=3", ram[0], lat);
      end
      doReq(1'b0, 2'b01, 1'b1, 32'h1001_0000, 32'h0, lat, rd, er, nRd, nWr);
      checks++;
      if (rd !== 32'h0000_1234) begin
         failures++;
         $display("FAIL lh_after_sh got=%h exp=00001234", rd);
      end
   endtask

   task automatic test_store_word();
      int lat, nRd, nWr;
      logic [31:0] rd;
      logic er;
      doReq(1'b1, 2'b10, 1'b0, 32'h1001_0010, 32'hDEAD_BEEF, lat, rd, er, nRd, nWr);
      checks++;
      if (ram[4] !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL sw_ram got=%h exp=deadbeef", ram[4]);
      end
      checks++;
      if (lat != 2 || nRd != 0 || nWr != 1 || rd !== 32'h0) begin
         failures++;
         $display("FAIL sw_timing got lat=%0d rd=%0d wr=%0d rdata=%h exp 2 0 1 0", lat, nRd, nWr, rd);
      end
      doReq(1'b0, 2'b10, 1'b0, 32'h1001_0010, 32'h0, lat, rd, er, nRd, nWr);
      checks++;
      if (rd !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL lw_readback got=%h exp=deadbeef", rd);
      end
   endtask

   task automatic test_errors();
      logic        wr    [3] = '{1'b0, 1'b1, 1'b0};
      logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
      logic [31:0] addrs [3] = '{32'h1001_0002, 32'h1001_0001, 32'h1001_0000};
      int lat, nRd, nWr;
      logic [31:0] rd;
      logic er;
      for (int i = 0; i < 3; i++) begin
         doReq(wr[i], sizes[i], 1'b0, addrs[i], 32'hFFFF_FFFF, lat, rd, er, nRd, nWr);
         checks++;
         if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || nRd != 0 || nWr != 0) begin
            failures++;
            $display("FAIL err_%0d got err=%b rdata=%h lat=%0d rd=%0d wr=%0d exp 1 0 1 0 0", i, er, rd, lat, nRd, nWr);
         end
      end
      checks++;
      if (ram[0] !== 32'h8855_1234) begin
         failures++;
         $display("FAIL err_no_write got=%h exp=88551234", ram[0]);
      end
      doReq(1'b0, 2'b10, 1'b0, 32'h1001_0400, 32'h0, lat, rd, er, nRd, nWr);
`ifdef LSU_BOUNDS_CHECK_EN
      checks++;
      if (er !== 1'b1 || lat != 1 || nRd != 0) begin
         failures++;
         $display("FAIL bounds got err=%b lat=%0d rd=%0d exp err=1 lat=1 rd=0", er, lat, nRd);
      end
`else
      checks++;
      if (er !== 1'b0 || lat != 2 || nRd != 1) begin
         failures++;
         $display("FAIL bounds got err=%b lat=%0d rd=%0d exp err=0 lat=2 rd=1", er, lat, nRd);
      end
`endif
   endtask

   task automatic test_stall();
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h1001_0010; req_wdata = 32'h0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      // A store presented while busy must be dropped, not queued.
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_wdata = 32'h1111_1111;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || req_ready !== 1'b0 || MemWrite !== 1'b0) begin
            failures++;
            $display("FAIL stall_%0d got valid=%b rdata=%h ready=%b memwr=%b exp 1 deadbeef 0 0",
                     i, rsp_valid, rsp_rdata, req_ready, MemWrite);
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (ram[4] !== 32'hDEAD_BEEF || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL stall_ignored got ram4=%h valid=%b ready=%b exp deadbeef 0 1", ram[4], rsp_valid, req_ready);
      end
   endtask

   task automatic test_reset_mid_rmw();
      int seen;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h1001_0011; req_wdata = 32'h0000_0077;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (MemRead !== 1'b1 || Address !== 32'd4) begin
         failures++;
         $display("FAIL rmw_rd_phase got memrd=%b addr=%h exp 1 4", MemRead, Address);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({MemRead, MemWrite, rsp_valid, req_ready} !== 4'b0001 || Address !== 32'h0 || WriteData !== 32'h0) begin
         failures++;
         $display("FAIL mid_reset got rd=%b wr=%b valid=%b ready=%b addr=%h wdata=%h exp 0 0 0 1 0 0",
                  MemRead, MemWrite, rsp_valid, req_ready, Address, WriteData);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid || MemWrite) seen++;
      end
      checks++;
      if (seen != 0 || ram[4] !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL mid_reset_after got activity=%0d ram4=%h exp 0 deadbeef", seen, ram[4]);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store_subword();
      test_store_word();
      test_errors();
      test_stall();
      test_reset_mid_rmw();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
